cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_responder.sv
// CPU bus slave: mirrored 2 KiB RAM, programmable down-counting timer with IRQ, optional NMI generator.
// Optional NMI generator is compiled in when CPU_BUS_RESPONDER_NMI_GEN_EN is defined.
//
// state | meaning
// IDLE  | waiting for G_phy2 to qualify a new access
// WAIT  | stalling for the configured wait states
// ACK   | access committed; G_ready follows on the next edge
module cpu_bus_responder #(
    parameter int RAM_AWIDTH  = 11,
    parameter int WAIT_STATES = 1,
    parameter int NMI_PERIOD  = 29780
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic [15:0] G_addr,
    input  logic [7:0]  G_wr_data,
    input  logic        G_rdwr,
    input  logic        G_phy2,
    input  logic        G_sync,
    output logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        G_irq,
    output logic        G_nmi
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;

    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        rdwr_q;

    logic [15:0] acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_rdwr;
    logic        accept, commit, ready_nxt;
    logic        wr_en, rd_en;
    logic        sel_ram, sel_lo, sel_hi, sel_ctrl;
    logic [7:0]  rd_mux;

    logic [7:0]  mem [0:(1 << RAM_AWIDTH) - 1];
    logic [7:0]  timer_lo, timer_hi;
    logic [2:0]  ctrl;
    logic [15:0] tmr_cnt, tmr_cnt_nxt;
    logic        tmr_uf, irq_flag, flag_clr;
    logic        ctrl2_wr;

    always_ff @(posedge G_clock or posedge G_reset) begin
        if (G_reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (G_phy2) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = ACK;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == IDLE) && G_phy2;
        commit    = (state_nxt == ACK) && (state != ACK);
        ready_nxt = (state == ACK);
    end

    // With zero wait states the commit edge is the accept edge, so use the live bus.
    assign acc_addr  = (state == IDLE) ? G_addr    : addr_q;
    assign acc_wdata = (state == IDLE) ? G_wr_data : wdata_q;
    assign acc_rdwr  = (state == IDLE) ? G_rdwr    : rdwr_q;

    assign sel_ram  = (acc_addr[15:13] == 3'b000);
    assign sel_lo   = (acc_addr == 16'h4020);
    assign sel_hi   = (acc_addr == 16'h4021);
    assign sel_ctrl = (acc_addr == 16'h4022);

    assign wr_en = commit && !acc_rdwr && !G_reset;
    assign rd_en = commit &&  acc_rdwr;

    always_comb begin
        rd_mux = 8'hFF;
        if (sel_ram)       rd_mux = mem[acc_addr[RAM_AWIDTH-1:0]];
        else if (sel_lo)   rd_mux = timer_lo;
        else if (sel_hi)   rd_mux = timer_hi;
        else if (sel_ctrl) rd_mux = {irq_flag, 4'b0000, ctrl};
    end

`ifdef CPU_BUS_RESPONDER_NMI_GEN_EN
    assign ctrl2_wr = acc_wdata[2];
`else
    assign ctrl2_wr = 1'b0;
`endif

    always_comb begin
        tmr_cnt_nxt = tmr_cnt;
        tmr_uf      = 1'b0;
        if (ctrl[0] && (tmr_cnt != 16'd0)) begin
            if (tmr_cnt == 16'd1) begin
                tmr_uf      = 1'b1;
                tmr_cnt_nxt = {timer_hi, timer_lo};
            end else begin
                tmr_cnt_nxt = tmr_cnt - 16'd1;
            end
        end
        if (wr_en && sel_hi) tmr_cnt_nxt = {acc_wdata, timer_lo};
    end

    assign flag_clr = sel_ctrl && (rd_en || (wr_en && acc_wdata[7]));

    // RAM is deliberately left out of reset so its contents survive it.
    always_ff @(posedge G_clock) begin
        if (wr_en && sel_ram) mem[acc_addr[RAM_AWIDTH-1:0]] <= acc_wdata;
    end

    always_ff @(posedge G_clock or posedge G_reset) begin
        if (G_reset) begin
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            rdwr_q    <= 1'b1;
            G_rd_data <= 8'h00;
            G_ready   <= 1'b0;
            timer_lo  <= 8'h00;
            timer_hi  <= 8'h00;
            ctrl      <= 3'b000;
            tmr_cnt   <= 16'h0000;
            irq_flag  <= 1'b0;
        end else begin
            G_ready <= ready_nxt;
            tmr_cnt <= tmr_cnt_nxt;
            if (accept) begin
                addr_q  <= G_addr;
                wdata_q <= G_wr_data;
                rdwr_q  <= G_rdwr;
            end
            if (rd_en) G_rd_data <= rd_mux;
            if (wr_en && sel_lo)   timer_lo <= acc_wdata;
            if (wr_en && sel_hi)   timer_hi <= acc_wdata;
            if (wr_en && sel_ctrl) ctrl     <= {ctrl2_wr, acc_wdata[1:0]};
            // Underflow wins over a simultaneous clear.
            if (tmr_uf)        irq_flag <= 1'b1;
            else if (flag_clr) irq_flag <= 1'b0;
        end
    end

    assign G_irq = irq_flag & ctrl[1];

`ifdef CPU_BUS_RESPONDER_NMI_GEN_EN
    localparam int NMI_W = (NMI_PERIOD > 15) ? $clog2(NMI_PERIOD + 1) : 5;
    logic [NMI_W-1:0] nmi_cnt;

    always_ff @(posedge G_clock or posedge G_reset) begin
        if (G_reset)                                  nmi_cnt <= '0;
        else if (nmi_cnt == NMI_W'(NMI_PERIOD - 1))   nmi_cnt <= '0;
        else                                          nmi_cnt <= nmi_cnt + 1'b1;
    end

    assign G_nmi = ctrl[2] && (nmi_cnt < NMI_W'(8));
`else
    assign G_nmi = 1'b0;
    logic unused_nmi;
    assign unused_nmi = (NMI_PERIOD == 0);
`endif

    logic unused_sync;
    assign unused_sync = G_sync;

endmodule
